// File: rtl/mul24_divchk.sv
// Sequential shift-add multiply-accumulate (multiplier*multiplicand + addend) used to
// rebuild a divider's dividend and flag whether quotient/remainder are consistent.
module mul24_divchk #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CW    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   addend,
  input  logic [WIDTH-1:0]   expected,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               match
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ADD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_capture;
  logic             w_step;
  logic             w_finish;

  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_addend;
  logic [WIDTH-1:0] r_expected;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [PW-1:0]    r_product;
  logic             r_match;

  logic [WIDTH:0]   w_part;
  logic [WIDTH:0]   w_sum;
  logic [PW-1:0]    w_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        w_step = 1'b1;
        if (r_count == CW'(WIDTH - 1)) w_state_nxt = S_ADD;
      end
      S_ADD: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One radix-2 partial product per MUL cycle; A never exceeds WIDTH+1 bits.
  assign w_part = r_q[0] ? {1'b0, r_m} : '0;
  assign w_sum  = r_a + w_part;
  assign w_full = {r_a[WIDTH-1:0], r_q} + PW'(r_addend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m        <= '0;
      r_a        <= '0;
      r_q        <= '0;
      r_addend   <= '0;
      r_expected <= '0;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_product  <= '0;
      r_match    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_m        <= multiplicand;
        r_q        <= multiplier;
        r_addend   <= addend;
        r_expected <= expected;
        r_a        <= '0;
        r_count    <= '0;
        r_busy     <= 1'b1;
      end
      if (w_step) begin
        r_a     <= {1'b0, w_sum[WIDTH:1]};
        r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
        r_count <= r_count + CW'(1);
      end
      // Remainder must also be below the divisor for the quotient to be valid.
      if (w_finish) begin
        r_product <= w_full;
        r_match   <= (w_full == PW'(r_expected)) && (r_addend < r_m);
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign match   = r_match;

endmodule

// File: tb/tb_mul24_divchk.sv
// Directed bench for mul24_divchk: expected results queued at start, popped on done.
module tb_mul24_divchk;

  localparam int unsigned W = 24;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           mat;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   addend;
  logic [W-1:0]   expected;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           match;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   cyc    = 0;

  mul24_divchk #(.WIDTH(W), .CW(5)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .addend(addend), .expected(expected),
    .busy(busy), .done(done), .product(product), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard consumer: every done must match the oldest queued request.
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        check("done_unexpected", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", 64'(product), 64'(e.prod));
        check("match", 64'(match), 64'(e.mat));
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] m, input logic [W-1:0] q,
                                 input logic [W-1:0] a, input logic [W-1:0] e);
    exp_t r;
    r.prod = (2*W)'(m) * (2*W)'(q) + (2*W)'(a);
    r.mat  = (r.prod == (2*W)'(e)) && (a < m);
    return r;
  endfunction

  task automatic set_ops(input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [W-1:0] a, input logic [W-1:0] e);
    multiplicand = m;
    multiplier   = q;
    addend       = a;
    expected     = e;
  endtask

  // Called #1 after an edge; the next edge is edge 0. Returns #1 after edge 0.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [W-1:0] a, input logic [W-1:0] e);
    set_ops(m, q, a, e);
    start = 1'b1;
    sb_q.push_back(model(m, q, a, e));
    @(posedge clk); #1;
    start = 1'b0;
    set_ops($urandom(), $urandom(), $urandom(), $urandom());
    check("busy_edge0", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(output int t);
    int k;
    t = -1;
    for (k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    int t0, t1, nd;
    rst   = 1'b1;
    start = 1'b0;
    set_ops('0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_match", 64'(match), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic latency: busy for edges 0..24, done exactly after edge 25.
    start_op(24'd7, 24'd14, 24'd2, 24'd100);
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      check("busy_mul", 64'(busy), 64'd1);
      check("done_early", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    check("done_edge25", 64'(done), 64'd1);
    check("busy_edge25", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", 64'(done), 64'd0);
    check("product_hold", 64'(product), 64'd100);

    start_op(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    wait_done(t0);
    check("max_product", 64'(product), 64'h0000_FFFF_FF00_0000);
    @(posedge clk); #1;

    start_op(24'd7, 24'd13, 24'd9, 24'd100);
    wait_done(t0);
    @(posedge clk); #1;

    start_op(24'd0, 24'd5, 24'd3, 24'd3);
    wait_done(t0);
    @(posedge clk); #1;

    // Start pulse mid-operation must be ignored.
    nd = n_done;
    start_op(24'd7, 24'd14, 24'd2, 24'd100);
    repeat (4) @(posedge clk);
    #1;
    set_ops(24'd3, 24'd3, 24'd0, 24'd9);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t0);
    repeat (40) @(posedge clk);
    #1;
    check("ignored_start_dones", 64'(n_done - nd), 64'd1);

    // Reset mid-operation aborts without a done.
    nd = n_done;
    start_op(24'd1000, 24'd1000, 24'd999, 24'd0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", 64'(product), 64'd0);
    check("abort_match", 64'(match), 64'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_done", 64'(n_done - nd), 64'd0);
    start_op(24'd7, 24'd13, 24'd9, 24'd100);
    wait_done(t0);
    @(posedge clk); #1;

    // Back-to-back with start held high; operands switched in the done cycle.
    set_ops(24'd7, 24'd14, 24'd2, 24'd100);
    start = 1'b1;
    sb_q.push_back(model(24'd7, 24'd14, 24'd2, 24'd100));
    wait_done(t0);
    set_ops(24'd1000, 24'd1000, 24'd999, 24'd0);
    sb_q.push_back(model(24'd1000, 24'd1000, 24'd999, 24'd0));
    @(posedge clk); #1;
    set_ops($urandom(), $urandom(), $urandom(), $urandom());
    wait_done(t1);
    start = 1'b0;
    check("b2b_spacing", 64'(t1 - t0), 64'd26);
    check("b2b_product", 64'(product), 64'd1000999);
    repeat (30) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul24_divchk.md
Name: mul24_divchk

Overview:
- Sequential radix-2 shift-add multiply-accumulate unit. It computes product = multiplier × multiplicand + addend for 24-bit operands.
- It sits on the result side of the 24-bit non-restoring divider and reconstructs the dividend from quotient, divisor and remainder (quo × divisor + rem).
- It flags whether the reconstruction matches an expected dividend and whether the remainder is in range, so it serves as the inverse operation and the in-system checker for the divider.

Parameters:
- WIDTH, 24, operand width; the product is 2×WIDTH bits.
- CW, 5, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WIDTH  divisor operand.
- multiplier  input  WIDTH  quotient operand.
- addend  input  WIDTH  remainder operand.
- expected  input  WIDTH  expected dividend for comparison.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when product and match are updated.
- product  output  2*WIDTH  multiplier × multiplicand + addend, held until the next done.
- match  output  1  valid with done, held until the next done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
  - While rst=1: state=IDLE, busy=0, done=0, product=0, match=0, all internal registers 0.
  - Reset during MUL or ADD aborts the operation; no done is produced for it.
- Operand capture: at the edge where state=IDLE and start=1 (edge 0), latch multiplicand, multiplier, addend and expected into internal registers. Then:
  - A (WIDTH+1 bits) <= 0, Q <= multiplier, count <= 0, busy <= 1, state <= MUL.
  - Inputs may change freely after edge 0.
- MUL state, one iteration per edge, WIDTH iterations (edges 1..WIDTH):
  - sum = A + (Q[0] ? M : 0), computed in WIDTH+1 bits.
  - {A,Q} <= {sum, Q} >> 1, a logical shift of the (2×WIDTH+1)-bit concatenation.
  - count <= count + 1. At the edge where count = WIDTH-1, state <= ADD.
- ADD state (edge WIDTH+1):
  - product <= {A[WIDTH-1:0], Q} + zero-extended addend.
  - match <= (that same sum == zero-extended expected) && (addend < multiplicand).
  - done <= 1, busy <= 0, state <= IDLE.
- Overflow: the maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, so no overflow is possible and there is no carry-out port.
- Latency: done is high for exactly the one cycle following edge WIDTH+1, i.e. edge 25 for WIDTH=24.
  - Throughput is one operation per WIDTH+2 cycles when start is back-to-back.
- done: a registered one-cycle pulse. It is cleared on the next edge unless another completion occurs on that edge, which is impossible given the minimum latency.
- start handling:
  - start while busy=1 is ignored, with no queuing.
  - start in the cycle done=1 is accepted, since state is already IDLE.
  - start held high continuously begins a new operation every WIDTH+2 cycles.
- Divisor zero: multiplicand=0 makes (addend < 0) false, so match=0 always. The product is still computed as equal to addend.
- match requires both conditions, so a product equal to expected with addend ≥ multiplicand gives match=0.
- product and match change only at done or at reset.

Test Plan:
- Reset then start with multiplicand=7, multiplier=14, addend=2, expected=100 -> busy high edges 0..24; done pulses after edge 25; product=100; match=1.
- Start with multiplicand=0xFFFFFF, multiplier=0xFFFFFF, addend=0xFFFFFF, expected=0xFFFFFF -> product=0xFFFFFF000000, match=0 (upper half nonzero).
- Start with multiplicand=7, multiplier=13, addend=9, expected=100 -> product=100, match=0 (remainder ≥ divisor).
- Start with multiplicand=0, multiplier=5, addend=3, expected=3 -> product=3, match=0.
- Start with 7,14,2 then pulse start again at edge 5 with 3,3,0 -> second request ignored; result is product=100.
  - Then assert rst at edge 10 of a new operation -> busy=0, done=0, product=0 immediately; no done follows.
  - Then restart -> completes normally.
- Back-to-back: start held high with operand sets (7,14,2,100) then (1000,1000,999,0) switched during the first done cycle -> done pulses exactly 26 cycles apart; products are 100 then 1000999; match is 1 then 0.
